eq_step_ctrl: RTL and testbench

EQ_STEP_CTRL -- requirements
Module: eq_step_ctrl

---
 rtl/eq_pkg.sv | 18 +
 rtl/eq_step_ctrl_if.sv | 36 +++
 rtl/eq_drain_ctr.sv | 56 +++++
 rtl/eq_step_ctrl.sv | 132 +++++++++++++
 tb/tb_eq_step_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eq_pkg.sv
// Shared FSM state encoding and default parameters for the lock-step
// equivalence step controller.
package eq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_MAX_CYC   = 35;
  localparam int DEF_DRAIN_CYC = 5;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/eq_step_ctrl_if.sv
// Control/compare bundle between the harness (master) and eq_step_ctrl (slave).
interface eq_step_ctrl_if
  import eq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic                     start;
  logic                     a_complete;
  logic                     b_complete;
  logic [NUM_CH-1:0]        a_valid;
  logic [NUM_CH-1:0]        b_valid;
  logic [NUM_CH*DATA_W-1:0] a_data;
  logic [NUM_CH*DATA_W-1:0] b_data;
  logic                     a_step;
  logic                     b_step;
  logic                     busy;
  logic                     done;
  logic                     timeout;
  logic [NUM_CH-1:0]        mismatch_mask;
  logic                     mismatch;
  logic [CNT_W-1:0]         cyc_cnt;

  modport master (
    output start, a_complete, b_complete, a_valid, b_valid, a_data, b_data,
    input  a_step, b_step, busy, done, timeout, mismatch_mask, mismatch, cyc_cnt
  );

  modport slave (
    input  start, a_complete, b_complete, a_valid, b_valid, a_data, b_data,
    output a_step, b_step, busy, done, timeout, mismatch_mask, mismatch, cyc_cnt
  );

endinterface

// File: rtl/eq_drain_ctr.sv
// Side-B drain counter: counts consecutive enabled cycles up to DRAIN_CYC+1
// and latches a sticky halted flag when the top is reached.
module eq_drain_ctr
  import eq_pkg::*;
#(
  parameter int DRAIN_CYC = DEF_DRAIN_CYC,
  parameter int CW        = $clog2(DRAIN_CYC + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          halted
);

  localparam logic [CW-1:0] CNT_TOP = CW'(DRAIN_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          halted_q, halted_d;

  // Next count: clr restarts everything; a gap in en drops the count but keeps halted.
  always_comb begin
    cnt_d    = cnt_q;
    halted_d = halted_q;
    if (clr) begin
      cnt_d    = {CW{1'b0}};
      halted_d = 1'b0;
    end else if (en) begin
      if (cnt_q == CNT_TOP) begin
        cnt_d = CNT_TOP;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      halted_d = halted_q | (cnt_d == CNT_TOP);
    end else begin
      cnt_d    = {CW{1'b0}};
      halted_d = halted_q;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= {CW{1'b0}};
      halted_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  assign cnt    = cnt_q;
  assign halted = halted_q;

endmodule

// File: rtl/eq_step_ctrl.sv
// Steps two designs in lock-step until both halt or a cycle bound expires,
// then compares their per-channel outputs.
module eq_step_ctrl
  import eq_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int MAX_CYC   = DEF_MAX_CYC,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst,
  eq_step_ctrl_if.slave bus
);

  localparam int DRW = $clog2(DRAIN_CYC + 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              a_halt_q, a_halt_d;
  logic              timeout_q, timeout_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              mismatch_q, mismatch_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NUM_CH-1:0] chk_mask;
  logic [DRW-1:0]    drain_cnt;
  logic              b_halt;
  logic              in_run;
  logic              hit_bound;
  logic              both_halted;

  assign in_run      = (state_q == ST_RUN);
  assign hit_bound   = (cyc_q == CNT_W'(MAX_CYC));
  assign both_halted = a_halt_q & b_halt;

  // Start clears the drain counter in every state, so a restart also wins over b_complete.
  eq_drain_ctr #(
    .DRAIN_CYC (DRAIN_CYC)
  ) u_drain (
    .clk    (clk),
    .rst    (rst),
    .clr    (bus.start),
    .en     (in_run & bus.b_complete),
    .cnt    (drain_cnt),
    .halted (b_halt)
  );

  // Per-channel compare: a valid disagreement or differing data on a valid channel.
  always_comb begin
    chk_mask = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      chk_mask[i] = (bus.a_valid[i] != bus.b_valid[i]) |
                    (bus.a_valid[i] &
                     (bus.a_data[i*DATA_W +: DATA_W] != bus.b_data[i*DATA_W +: DATA_W]));
    end
  end

  // Next-state and next-output logic; start overrides everything, including completions.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    a_halt_d  = a_halt_q;
    timeout_d = timeout_q;
    mask_d    = mask_q;
    if (bus.start) begin
      state_d   = ST_RUN;
      cyc_d     = {CNT_W{1'b0}};
      a_halt_d  = 1'b0;
      timeout_d = 1'b0;
      mask_d    = {NUM_CH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          cyc_d    = hit_bound ? cyc_q : (cyc_q + CNT_W'(1));
          a_halt_d = a_halt_q | bus.a_complete;
          if (both_halted | hit_bound) begin
            state_d   = ST_CHECK;
            timeout_d = hit_bound & ~both_halted;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_CHECK: begin
          state_d = ST_DONE;
          mask_d  = chk_mask;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d     = (state_d == ST_RUN) | (state_d == ST_CHECK);
    done_d     = (state_d == ST_DONE);
    mismatch_d = |mask_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cyc_q      <= {CNT_W{1'b0}};
      a_halt_q   <= 1'b0;
      timeout_q  <= 1'b0;
      mask_q     <= {NUM_CH{1'b0}};
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      a_halt_q   <= a_halt_d;
      timeout_q  <= timeout_d;
      mask_q     <= mask_d;
      mismatch_q <= mismatch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.a_step        = in_run & ~a_halt_q & ~bus.a_complete;
  assign bus.b_step        = in_run & (drain_cnt <= DRW'(DRAIN_CYC));
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.timeout       = timeout_q;
  assign bus.mismatch_mask = mask_q;
  assign bus.mismatch      = mismatch_q;
  assign bus.cyc_cnt       = cyc_q;

endmodule

// File: tb/tb_eq_step_ctrl.sv
// Directed self-checking bench for eq_step_ctrl (default parameters).
module tb_eq_step_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  eq_step_ctrl_if #(.DATA_W(8), .NUM_CH(2), .CNT_W(16)) bus ();

  eq_step_ctrl #(
    .DATA_W(8), .NUM_CH(2), .MAX_CYC(35), .DRAIN_CYC(5), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input int c, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%b exp=%b", name, c, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({bus.busy, bus.done, bus.timeout, bus.mismatch, bus.mismatch_mask, bus.a_step, bus.b_step} !== 8'h00 || bus.cyc_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b done=%b cyc=%0d exp all zero", bus.busy, bus.done, bus.cyc_cnt);
    end
    rst = 1'b0;
    step();
    step();
    chk1("idle_wait_busy", 0, bus.busy, 1'b0);
    chk1("idle_wait_astep", 0, bus.a_step, 1'b0);
  endtask

  task automatic test_both_halt();
    bus.a_valid = 2'b11; bus.b_valid = 2'b11;
    bus.a_data = 16'h5a5a; bus.b_data = 16'h5a5a;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c <= 14; c++) begin
      bus.a_complete = (c == 4);
      bus.b_complete = (c >= 6);
      #1;
      if (c <= 12) begin
        n_checks++;
        if (bus.cyc_cnt !== 16'(c)) begin
          n_fail++;
          $display("FAIL both_halt_cyc cycle=%0d got=%0d exp=%0d", c, bus.cyc_cnt, c);
        end
        chk1("both_halt_astep", c, bus.a_step, (c < 4));
        chk1("both_halt_bstep", c, bus.b_step, (c <= 11));
        chk1("both_halt_busy", c, bus.busy, 1'b1);
      end
      if (c == 13) begin
        chk1("check_busy", c, bus.busy, 1'b1);
        chk1("check_done", c, bus.done, 1'b0);
        chk1("check_bstep", c, bus.b_step, 1'b0);
      end
      if (c == 14) begin
        chk1("done_done", c, bus.done, 1'b1);
        chk1("done_busy", c, bus.busy, 1'b0);
        chk1("done_mismatch", c, bus.mismatch, 1'b0);
        chk1("done_timeout", c, bus.timeout, 1'b0);
      end
      step();
    end
    bus.a_complete = 1'b0;
    bus.b_complete = 1'b0;
  endtask

  task automatic test_mismatch();
    logic [1:0]  av [4] = '{2'b10, 2'b00, 2'b11, 2'b11};
    logic [1:0]  bv [4] = '{2'b11, 2'b00, 2'b11, 2'b11};
    logic [15:0] ad [4] = '{16'h3344, 16'h00ff, 16'h1022, 16'h1122};
    logic [15:0] bd [4] = '{16'h3344, 16'hff00, 16'h1122, 16'h1123};
    logic [1:0]  em [4] = '{2'b01, 2'b00, 2'b10, 2'b01};
    for (int v = 0; v < 4; v++) begin
      int k = 0;
      bus.a_valid = av[v]; bus.b_valid = bv[v];
      bus.a_data = ad[v]; bus.b_data = bd[v];
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.a_complete = 1'b1;
      bus.b_complete = 1'b1;
      while (bus.done !== 1'b1 && k < 50) begin
        step();
        k++;
      end
      chk1("mm_done_reached", v, bus.done, 1'b1);
      n_checks++;
      if (bus.mismatch_mask !== em[v]) begin
        n_fail++;
        $display("FAIL mm_mask vec=%0d got=%b exp=%b", v, bus.mismatch_mask, em[v]);
      end
      chk1("mm_mismatch", v, bus.mismatch, |em[v]);
      chk1("mm_timeout", v, bus.timeout, 1'b0);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_checks++;
    if (bus.mismatch_mask !== 2'b00 || bus.mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL mm_restart_clear got mask=%b mismatch=%b exp 00/0", bus.mismatch_mask, bus.mismatch);
    end
    bus.a_complete = 1'b0;
    bus.b_complete = 1'b0;
  endtask

  task automatic test_timeout();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c <= 37; c++) begin
      #1;
      if (c <= 35) begin
        n_checks++;
        if (bus.cyc_cnt !== 16'(c)) begin
          n_fail++;
          $display("FAIL to_cyc cycle=%0d got=%0d exp=%0d", c, bus.cyc_cnt, c);
        end
        chk1("to_bstep_run", c, bus.b_step, 1'b1);
      end
      if (c == 35) chk1("to_not_yet", c, bus.timeout, 1'b0);
      if (c >= 36) begin
        n_checks++;
        if (bus.cyc_cnt !== 16'd35) begin
          n_fail++;
          $display("FAIL to_sat cycle=%0d got=%0d exp=35", c, bus.cyc_cnt);
        end
        chk1("to_timeout", c, bus.timeout, 1'b1);
        chk1("to_bstep_off", c, bus.b_step, 1'b0);
        chk1("to_astep_off", c, bus.a_step, 1'b0);
        chk1("to_done", c, bus.done, (c == 37));
      end
      step();
    end
  endtask

  task automatic test_drain_restart();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c <= 14; c++) begin
      bus.b_complete = (c >= 2 && c != 5);
      #1;
      chk1("dr_bstep", c, bus.b_step, (c <= 11));
      chk1("dr_astep", c, bus.a_step, 1'b1);
      step();
    end
    bus.b_complete = 1'b0;
  endtask

  task automatic test_reset_priority();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk1("rp_busy_before", 10, bus.busy, 1'b1);
    chk1("rp_bstep_before", 10, bus.b_step, 1'b1);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.timeout, bus.mismatch, bus.mismatch_mask, bus.a_step, bus.b_step} !== 8'h00 || bus.cyc_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rp_async_reset got busy=%b cyc=%0d astep=%b bstep=%b exp all zero", bus.busy, bus.cyc_cnt, bus.a_step, bus.b_step);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk1("rp_no_done", c, bus.done, 1'b0);
    end
    chk1("rp_idle_busy", 0, bus.busy, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    bus.start = 1'b1;
    bus.a_complete = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a_complete = 1'b0;
    #1;
    n_checks++;
    if (bus.cyc_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rp_start_wins_cyc got=%0d exp=0", bus.cyc_cnt);
    end
    chk1("rp_start_wins_ahalt", 0, bus.a_step, 1'b1);
    step();
    n_checks++;
    if (bus.cyc_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL rp_after_restart_cyc got=%0d exp=1", bus.cyc_cnt);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_fail = 0;
    bus.start = 1'b0;
    bus.a_complete = 1'b0;
    bus.b_complete = 1'b0;
    bus.a_valid = 2'b00;
    bus.b_valid = 2'b00;
    bus.a_data = 16'h0000;
    bus.b_data = 16'h0000;
    test_reset();
    test_both_halt();
    test_mismatch();
    test_timeout();
    test_drain_restart();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
